arf_multiport: RTL and testbench

- Parametrised successor to the single-port Arf: the architectural register file with per-register busy bit and rename (RRF) tag.
- Serves DISPATCH_WIDTH rename lanes with two source reads each. Accepts DISPATCH_WIDTH set-busy requests and COMMIT_WIDTH retirement writes per cycle.
- New over Arf: a flush input that cancels all in-flight renames, a hardwired x0, and defined intra-cycle priority.
- Sits between the rename/dispatch stage and the ROB/RRF commit path.

---
 rtl/arf_multiport_pkg.sv | 15 +
 rtl/arf_multiport_entry_ctrl.sv | 58 +++++
 rtl/arf_multiport.sv | 123 ++++++++++++
 tb/tb_arf_multiport.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_multiport_pkg.sv
// rtl/arf_multiport_pkg.sv - shared widths and types for the multiport architectural register file
package arf_multiport_pkg;

  localparam int REG_SEL                = 5;
  localparam int DATA_LEN               = 32;
  localparam int RRF_SEL                = 6;
  localparam int NUM_REGS_DEFAULT       = 1 << REG_SEL;
  localparam int DISPATCH_WIDTH_DEFAULT = 2;
  localparam int COMMIT_WIDTH_DEFAULT   = 2;

  typedef logic [REG_SEL-1:0]  reg_idx_t;
  typedef logic [DATA_LEN-1:0] data_t;
  typedef logic [RRF_SEL-1:0]  rrf_tag_t;

endpackage

// File: rtl/arf_multiport_entry_ctrl.sv
// rtl/arf_multiport_entry_ctrl.sv - next busy/tag for one architectural register from decoded hits
module arf_entry_ctrl
  import arf_multiport_pkg::*;
#(
  parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEFAULT,
  parameter int COMMIT_WIDTH   = COMMIT_WIDTH_DEFAULT
) (
  input  logic                              busy_q,
  input  rrf_tag_t                          tag_q,
  input  logic [DISPATCH_WIDTH-1:0]         sb_hit,
  input  logic [DISPATCH_WIDTH*RRF_SEL-1:0] sb_tags,
  input  logic [COMMIT_WIDTH-1:0]           cm_hit,
  input  logic [COMMIT_WIDTH*RRF_SEL-1:0]   cm_tags,
  input  logic                              flush,
  output logic                              busy_d,
  output rrf_tag_t                          tag_d
);

  logic sb_any;
  logic cm_clear;
  rrf_tag_t sb_tag;

  // Ascending scan: the youngest (highest) lane leaves its tag last.
  always_comb begin
    sb_any = 1'b0;
    sb_tag = tag_q;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (sb_hit[k]) begin
        sb_any = 1'b1;
        sb_tag = sb_tags[k*RRF_SEL +: RRF_SEL];
      end
    end
  end

  always_comb begin
    cm_clear = 1'b0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (cm_hit[j] && (cm_tags[j*RRF_SEL +: RRF_SEL] == tag_q)) begin
        cm_clear = 1'b1;
      end
    end
  end

  // A stale tag on commit means a younger rename still owns the register.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (sb_any) begin
      busy_d = 1'b1;
      tag_d  = sb_tag;
    end else if (busy_q && cm_clear) begin
      busy_d = 1'b0;
    end
  end

endmodule

// File: rtl/arf_multiport.sv
// rtl/arf_multiport.sv - architectural register file with busy/rename tag, multi-lane rename and commit
module arf_multiport
  import arf_multiport_pkg::*;
#(
  parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEFAULT,
  parameter int COMMIT_WIDTH   = COMMIT_WIDTH_DEFAULT,
  parameter int NUM_REGS       = NUM_REGS_DEFAULT
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [DISPATCH_WIDTH*REG_SEL-1:0]  rs1_i,
  input  logic [DISPATCH_WIDTH*REG_SEL-1:0]  rs2_i,
  output logic [DISPATCH_WIDTH*DATA_LEN-1:0] rs1_data_o,
  output logic [DISPATCH_WIDTH*DATA_LEN-1:0] rs2_data_o,
  output logic [DISPATCH_WIDTH-1:0]          rs1_busy_o,
  output logic [DISPATCH_WIDTH-1:0]          rs2_busy_o,
  output logic [DISPATCH_WIDTH*RRF_SEL-1:0]  rs1_rrftag_o,
  output logic [DISPATCH_WIDTH*RRF_SEL-1:0]  rs2_rrftag_o,
  input  logic [DISPATCH_WIDTH-1:0]          setbusy_en_i,
  input  logic [DISPATCH_WIDTH*REG_SEL-1:0]  setbusy_dst_i,
  input  logic [DISPATCH_WIDTH*RRF_SEL-1:0]  setbusy_tag_i,
  input  logic [COMMIT_WIDTH-1:0]            commit_we_i,
  input  logic [COMMIT_WIDTH*REG_SEL-1:0]    commit_dst_i,
  input  logic [COMMIT_WIDTH*DATA_LEN-1:0]   commit_data_i,
  input  logic [COMMIT_WIDTH*RRF_SEL-1:0]    commit_tag_i,
  input  logic                               flush_i
);

  data_t               data_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  rrf_tag_t            tag_q  [NUM_REGS];
  rrf_tag_t            tag_d  [NUM_REGS];

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    logic [DISPATCH_WIDTH-1:0] sb_hit;
    logic [COMMIT_WIDTH-1:0]   cm_hit;

    // x0 never sees a hit, so it stays at its reset value forever.
    always_comb begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        sb_hit[k] = (r != 0) && setbusy_en_i[k] &&
                    (setbusy_dst_i[k*REG_SEL +: REG_SEL] == reg_idx_t'(r));
      end
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        cm_hit[j] = (r != 0) && commit_we_i[j] &&
                    (commit_dst_i[j*REG_SEL +: REG_SEL] == reg_idx_t'(r));
      end
    end

    arf_entry_ctrl #(
      .DISPATCH_WIDTH(DISPATCH_WIDTH),
      .COMMIT_WIDTH  (COMMIT_WIDTH)
    ) u_entry (
      .busy_q (busy_q[r]),
      .tag_q  (tag_q[r]),
      .sb_hit (sb_hit),
      .sb_tags(setbusy_tag_i),
      .cm_hit (cm_hit),
      .cm_tags(commit_tag_i),
      .flush  (flush_i),
      .busy_d (busy_d[r]),
      .tag_d  (tag_d[r])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_q[r] <= tag_d[r];
      end
    end
  end

  // Later ports overwrite earlier ones, so the youngest commit wins the data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_we_i[j] && (commit_dst_i[j*REG_SEL +: REG_SEL] != '0)) begin
          data_q[commit_dst_i[j*REG_SEL +: REG_SEL]] <= commit_data_i[j*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_read
    reg_idx_t idx1;
    reg_idx_t idx2;

    assign idx1 = rs1_i[k*REG_SEL +: REG_SEL];
    assign idx2 = rs2_i[k*REG_SEL +: REG_SEL];

    always_comb begin
      rs1_data_o[k*DATA_LEN +: DATA_LEN]  = '0;
      rs1_busy_o[k]                       = 1'b0;
      rs1_rrftag_o[k*RRF_SEL +: RRF_SEL]  = '0;
      rs2_data_o[k*DATA_LEN +: DATA_LEN]  = '0;
      rs2_busy_o[k]                       = 1'b0;
      rs2_rrftag_o[k*RRF_SEL +: RRF_SEL]  = '0;
      if (idx1 != '0) begin
        rs1_data_o[k*DATA_LEN +: DATA_LEN] = data_q[idx1];
        rs1_busy_o[k]                      = busy_q[idx1];
        rs1_rrftag_o[k*RRF_SEL +: RRF_SEL] = tag_q[idx1];
      end
      if (idx2 != '0) begin
        rs2_data_o[k*DATA_LEN +: DATA_LEN] = data_q[idx2];
        rs2_busy_o[k]                      = busy_q[idx2];
        rs2_rrftag_o[k*RRF_SEL +: RRF_SEL] = tag_q[idx2];
      end
    end
  end

endmodule

// File: tb/tb_arf_multiport.sv
// tb/tb_arf_multiport.sv - scoreboard bench for arf_multiport with a behavioural register-file model
module tb_arf_multiport;
  import arf_multiport_pkg::*;

  localparam int DW = 2;
  localparam int CW = 2;
  localparam int NR = 32;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                   reset_i;
  logic [DW*REG_SEL-1:0]  rs1_i, rs2_i;
  logic [DW*DATA_LEN-1:0] rs1_data_o, rs2_data_o;
  logic [DW-1:0]          rs1_busy_o, rs2_busy_o;
  logic [DW*RRF_SEL-1:0]  rs1_rrftag_o, rs2_rrftag_o;
  logic [DW-1:0]          setbusy_en_i;
  logic [DW*REG_SEL-1:0]  setbusy_dst_i;
  logic [DW*RRF_SEL-1:0]  setbusy_tag_i;
  logic [CW-1:0]          commit_we_i;
  logic [CW*REG_SEL-1:0]  commit_dst_i;
  logic [CW*DATA_LEN-1:0] commit_data_i;
  logic [CW*RRF_SEL-1:0]  commit_tag_i;
  logic                   flush_i;

  arf_multiport #(.DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .NUM_REGS(NR)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .rs1_rrftag_o(rs1_rrftag_o), .rs2_rrftag_o(rs2_rrftag_o),
    .setbusy_en_i(setbusy_en_i), .setbusy_dst_i(setbusy_dst_i), .setbusy_tag_i(setbusy_tag_i),
    .commit_we_i(commit_we_i), .commit_dst_i(commit_dst_i),
    .commit_data_i(commit_data_i), .commit_tag_i(commit_tag_i),
    .flush_i(flush_i)
  );

  // Behavioural model of the architectural state
  int unsigned m_data [NR];
  bit          m_busy [NR];
  int unsigned m_tag  [NR];

  // Stimulus for the next cycle
  int unsigned s_rs1 [DW], s_rs2 [DW];
  bit          s_sb_en [DW];
  int unsigned s_sb_dst [DW], s_sb_tag [DW];
  bit          s_cm_we [CW];
  int unsigned s_cm_dst [CW], s_cm_data [CW], s_cm_tag [CW];
  bit          s_flush, s_reset;

  typedef struct {
    int          lane;
    int          src;
    int unsigned idx;
    int unsigned data;
    bit          busy;
    int unsigned tag;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic clear_stim();
    for (int k = 0; k < DW; k++) begin
      s_rs1[k] = 0; s_rs2[k] = 0; s_sb_en[k] = 0; s_sb_dst[k] = 0; s_sb_tag[k] = 0;
    end
    for (int j = 0; j < CW; j++) begin
      s_cm_we[j] = 0; s_cm_dst[j] = 0; s_cm_data[j] = 0; s_cm_tag[j] = 0;
    end
    s_flush = 0; s_reset = 0;
  endtask

  function automatic exp_t predict(int lane, int src, int unsigned idx);
    exp_t e;
    e.lane = lane; e.src = src; e.idx = idx;
    e.data = (idx == 0) ? 0 : m_data[idx];
    e.busy = (idx == 0) ? 1'b0 : m_busy[idx];
    e.tag  = (idx == 0) ? 0 : m_tag[idx];
    return e;
  endfunction

  // Apply one clock edge worth of architectural rules to the model.
  task automatic model_edge();
    int unsigned old_tag [NR];
    bit          old_busy [NR];
    if (s_reset) begin
      for (int r = 0; r < NR; r++) begin
        m_data[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
      end
      return;
    end
    for (int r = 0; r < NR; r++) begin
      old_tag[r] = m_tag[r]; old_busy[r] = m_busy[r];
    end
    for (int j = 0; j < CW; j++) begin
      if (s_cm_we[j] && s_cm_dst[j] != 0) begin
        m_data[s_cm_dst[j]] = s_cm_data[j];
        if (old_busy[s_cm_dst[j]] && old_tag[s_cm_dst[j]] == s_cm_tag[j])
          m_busy[s_cm_dst[j]] = 0;
      end
    end
    if (s_flush) begin
      for (int r = 0; r < NR; r++) m_busy[r] = 0;
    end else begin
      for (int k = 0; k < DW; k++) begin
        if (s_sb_en[k] && s_sb_dst[k] != 0) begin
          m_busy[s_sb_dst[k]] = 1;
          m_tag[s_sb_dst[k]]  = s_sb_tag[k];
        end
      end
    end
  endtask

  task automatic step(input bit chk);
    reset_i = s_reset;
    flush_i = s_flush;
    for (int k = 0; k < DW; k++) begin
      rs1_i[k*REG_SEL +: REG_SEL]         = REG_SEL'(s_rs1[k]);
      rs2_i[k*REG_SEL +: REG_SEL]         = REG_SEL'(s_rs2[k]);
      setbusy_en_i[k]                     = s_sb_en[k];
      setbusy_dst_i[k*REG_SEL +: REG_SEL] = REG_SEL'(s_sb_dst[k]);
      setbusy_tag_i[k*RRF_SEL +: RRF_SEL] = RRF_SEL'(s_sb_tag[k]);
      if (chk) begin
        exp_q.push_back(predict(k, 1, s_rs1[k]));
        exp_q.push_back(predict(k, 2, s_rs2[k]));
      end
    end
    for (int j = 0; j < CW; j++) begin
      commit_we_i[j]                        = s_cm_we[j];
      commit_dst_i[j*REG_SEL +: REG_SEL]    = REG_SEL'(s_cm_dst[j]);
      commit_data_i[j*DATA_LEN +: DATA_LEN] = DATA_LEN'(s_cm_data[j]);
      commit_tag_i[j*RRF_SEL +: RRF_SEL]    = RRF_SEL'(s_cm_tag[j]);
    end
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_pair(int unsigned a, int unsigned b);
    clear_stim();
    s_rs1[0] = a; s_rs1[1] = b; s_rs2[0] = b; s_rs2[1] = a;
    step(1);
  endtask

  // Monitor: read outputs are valid every cycle; compare whatever was issued.
  always @(negedge clk_i) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      int unsigned ad, at;
      bit ab;
      e = exp_q.pop_front();
      if (e.src == 1) begin
        ad = rs1_data_o[e.lane*DATA_LEN +: DATA_LEN];
        ab = rs1_busy_o[e.lane];
        at = 32'(rs1_rrftag_o[e.lane*RRF_SEL +: RRF_SEL]);
      end else begin
        ad = rs2_data_o[e.lane*DATA_LEN +: DATA_LEN];
        ab = rs2_busy_o[e.lane];
        at = 32'(rs2_rrftag_o[e.lane*RRF_SEL +: RRF_SEL]);
      end
      n_cmp += 3;
      if (ad !== e.data) begin
        n_fail++;
        $display("FAIL data rs%0d lane%0d x%0d: got %h want %h", e.src, e.lane, e.idx, ad, e.data);
      end
      if (ab !== e.busy) begin
        n_fail++;
        $display("FAIL busy rs%0d lane%0d x%0d: got %0d want %0d", e.src, e.lane, e.idx, ab, e.busy);
      end
      if (at !== e.tag) begin
        n_fail++;
        $display("FAIL tag rs%0d lane%0d x%0d: got %0d want %0d", e.src, e.lane, e.idx, at, e.tag);
      end
    end
  end

  initial begin
    for (int r = 0; r < NR; r++) begin
      m_data[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
    end
    clear_stim();
    s_reset = 1;
    step(0);

    read_pair(1, 2);

    clear_stim();
    s_sb_en[0] = 1; s_sb_dst[0] = 1; s_sb_tag[0] = 12;
    s_sb_en[1] = 1; s_sb_dst[1] = 2; s_sb_tag[1] = 13;
    step(1);
    read_pair(1, 2);

    clear_stim();
    s_cm_we[0] = 1; s_cm_dst[0] = 1; s_cm_data[0] = 14; s_cm_tag[0] = 12;
    s_cm_we[1] = 1; s_cm_dst[1] = 2; s_cm_data[1] = 16; s_cm_tag[1] = 12;
    step(1);
    read_pair(1, 2);

    clear_stim();
    s_sb_en[0] = 1; s_sb_dst[0] = 3; s_sb_tag[0] = 5;
    step(1);
    clear_stim();
    s_cm_we[0] = 1; s_cm_dst[0] = 3; s_cm_data[0] = 32'h33; s_cm_tag[0] = 5;
    s_sb_en[0] = 1; s_sb_dst[0] = 3; s_sb_tag[0] = 7;
    step(1);
    clear_stim();
    s_sb_en[0] = 1; s_sb_dst[0] = 4; s_sb_tag[0] = 8;
    s_sb_en[1] = 1; s_sb_dst[1] = 4; s_sb_tag[1] = 9;
    s_cm_we[0] = 1; s_cm_dst[0] = 4; s_cm_data[0] = 32'h11;
    s_cm_we[1] = 1; s_cm_dst[1] = 4; s_cm_data[1] = 32'h22;
    step(1);
    read_pair(3, 4);

    clear_stim();
    s_sb_en[0] = 1; s_sb_dst[0] = 5; s_sb_tag[0] = 1;
    s_sb_en[1] = 1; s_sb_dst[1] = 6; s_sb_tag[1] = 2;
    step(1);
    clear_stim();
    s_flush = 1;
    s_sb_en[0] = 1; s_sb_dst[0] = 7; s_sb_tag[0] = 3;
    s_cm_we[0] = 1; s_cm_dst[0] = 5; s_cm_data[0] = 32'hAA; s_cm_tag[0] = 9;
    step(1);
    read_pair(5, 6);
    read_pair(7, 3);

    clear_stim();
    s_sb_en[1] = 1; s_sb_dst[1] = 0; s_sb_tag[1] = 4;
    s_cm_we[1] = 1; s_cm_dst[1] = 0; s_cm_data[1] = 32'hFF;
    step(1);
    read_pair(0, 0);

    clear_stim();
    s_reset = 1; s_flush = 1;
    s_sb_en[0] = 1; s_sb_dst[0] = 9; s_sb_tag[0] = 6;
    s_cm_we[0] = 1; s_cm_dst[0] = 3; s_cm_data[0] = 32'h55;
    step(1);
    read_pair(3, 4);
    read_pair(9, 1);

    for (int c = 0; c < 3000; c++) begin
      clear_stim();
      for (int k = 0; k < DW; k++) begin
        s_rs1[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR-1) : $urandom_range(0, 7);
        s_rs2[k] = $urandom_range(0, 7);
        s_sb_en[k]  = $urandom_range(0, 2) == 0;
        s_sb_dst[k] = $urandom_range(0, 7);
        s_sb_tag[k] = $urandom_range(0, (1 << RRF_SEL) - 1);
      end
      for (int j = 0; j < CW; j++) begin
        s_cm_we[j]   = $urandom_range(0, 1);
        s_cm_dst[j]  = $urandom_range(0, 7);
        s_cm_data[j] = $urandom;
        s_cm_tag[j]  = ($urandom_range(0, 1) == 0) ? m_tag[s_cm_dst[j]]
                                                   : $urandom_range(0, (1 << RRF_SEL) - 1);
      end
      s_flush = $urandom_range(0, 19) == 0;
      s_reset = $urandom_range(0, 99) == 0;
      step(1);
    end

    clear_stim();
    step(0);
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
